// File: rtl/kim_fifo_pkt_framer.sv
`default_nettype none
// ============================================================================
//  Module   : kim_fifo_pkt_framer
//  Purpose  : Groups a FIFO output stream into packets of up to MAX_LEN data
//             words and appends one trailer word {seq_num, word_count} marked
//             with m_last. A packet closes early on input idle timeout or on
//             an explicit flush. One registered output stage, fully
//             backpressurable on both sides.
//  Ports    : clk            rising-edge clock
//             rst            asynchronous reset, active low
//             s_valid/s_ready/s_data   input stream (from FIFO)
//             flush          one-cycle request to close a partial packet
//             m_valid/m_ready/m_data/m_last   output stream
//             busy           high while a packet is open or a trailer waits
//  Revision : 1.0  initial release
// ============================================================================
module kim_fifo_pkt_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LEN    = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    // Idle counter only needs to reach TIMEOUT; keep at least one bit so the
    // timeout-disabled build still elaborates.
    localparam int             IW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [15:0]    C_MAX = 16'(MAX_LEN);
    localparam logic [IW-1:0]  C_TO  = IW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_TRAILER = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [15:0]           r_cnt, w_cnt_nxt;
    logic [IW-1:0]         r_idle, w_idle_nxt;
    logic [15:0]           r_seq, w_seq_nxt;
    logic                  r_m_valid, w_mv_nxt;
    logic [DATA_WIDTH-1:0] r_m_data, w_md_nxt;
    logic                  r_m_last, w_ml_nxt;

    logic                  w_out_free;
    logic                  w_accept;
    logic [15:0]           w_cnt_inc;
    logic [IW-1:0]         w_idle_inc;
    logic [DATA_WIDTH-1:0] w_trailer;

    // Output register can take a new word when empty or draining this cycle.
    assign w_out_free = !r_m_valid || m_ready;
    assign s_ready    = w_out_free && (r_state != S_TRAILER);
    assign w_accept   = s_valid && s_ready;
    assign w_cnt_inc  = r_cnt + 16'd1;
    assign w_idle_inc = r_idle + IW'(1);

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign busy    = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idle_nxt  = r_idle;
        w_seq_nxt   = r_seq;
        w_mv_nxt    = r_m_valid;
        w_md_nxt    = r_m_data;
        w_ml_nxt    = r_m_last;

        w_trailer        = '0;
        w_trailer[31:0]  = {r_seq, r_cnt};

        // A drained (or empty) output stage goes invalid unless reloaded below.
        if (w_out_free) begin
            w_mv_nxt = 1'b0;
            w_ml_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_md_nxt    = s_data;
                    w_mv_nxt    = 1'b1;
                    w_cnt_nxt   = 16'd1;
                    w_idle_nxt  = '0;
                    w_state_nxt = (MAX_LEN == 1) ? S_TRAILER : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    w_md_nxt   = s_data;
                    w_mv_nxt   = 1'b1;
                    w_cnt_nxt  = w_cnt_inc;
                    w_idle_nxt = '0;
                    // A word arriving with flush still belongs to this packet.
                    if (w_cnt_inc == C_MAX || flush) begin
                        w_state_nxt = S_TRAILER;
                    end
                end else begin
                    // Counts both input-starved and output-stalled cycles.
                    w_idle_nxt = w_idle_inc;
                    if (TIMEOUT != 0 && w_idle_inc == C_TO) begin
                        w_state_nxt = S_TRAILER;
                    end else if (flush && w_out_free) begin
                        // Flush while a word is stalled in the output is dropped.
                        w_state_nxt = S_TRAILER;
                    end
                end
            end
            S_TRAILER: begin
                if (w_out_free) begin
                    w_md_nxt    = w_trailer;
                    w_mv_nxt    = 1'b1;
                    w_ml_nxt    = 1'b1;
                    w_seq_nxt   = r_seq + 16'd1;
                    w_cnt_nxt   = 16'd0;
                    w_idle_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_idle    <= '0;
            r_seq     <= 16'd0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idle    <= w_idle_nxt;
            r_seq     <= w_seq_nxt;
            r_m_valid <= w_mv_nxt;
            r_m_data  <= w_md_nxt;
            r_m_last  <= w_ml_nxt;
        end
    end

endmodule
`default_nettype wire
